// File: rtl/gray_generador.sv
// Prescaled up/down Gray-code source with a valid/ready output,
// synchronous preload, back-pressure hold and sticky overrun flag.
module gray_generador #(
    parameter int N        = 4,
    parameter int PRESCALE = 100000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up_down,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] gray,
    output logic [N-1:0] bin,
    output logic         wrap,
    output logic         overrun,
    input  logic         clr_ovr
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0] presc;
    logic          tick;
    logic          step;
    logic          accept;
    logic          drop;
    logic [N-1:0]  bin_nxt;
    logic          wrap_nxt;

    assign tick   = (state != IDLE) && (presc == LAST);
    assign step   = (state == RUN) && en && tick;
    assign accept = (state == WAIT) && out_ready;
    assign drop   = (state == WAIT) && tick;

    assign bin_nxt  = up_down ? bin + N'(1) : bin - N'(1);
    assign wrap_nxt = up_down ? (&bin) : ~(|bin);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = WAIT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) state_nxt = RUN;
                end
                RUN: begin
                    if (!en) state_nxt = IDLE;
                    else if (tick) state_nxt = WAIT;
                end
                WAIT: begin
                    if (out_ready) state_nxt = en ? RUN : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == WAIT);
    end

    // Prescaler only advances in RUN/WAIT, so entering RUN starts a full period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (load || tick || state == IDLE || state_nxt == IDLE) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            bin  <= load_val;
            gray <= load_val ^ (load_val >> 1);
            wrap <= 1'b0;
        end else if (step) begin
            bin  <= bin_nxt;
            gray <= bin_nxt ^ (bin_nxt >> 1);
            wrap <= wrap_nxt;
        end else if (accept) begin
            wrap <= 1'b0;
        end
    end

    // A dropped tick beats a coincident clear; a preload never counts as a drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop && !load) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_generador.sv
// Bench for gray_generador: directed scenarios plus a randomized run
// against a behavioural model of the step/hold/overrun rules.
module tb_gray_generador;

    localparam int N = 4;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up_down;
    logic         load;
    logic [N-1:0] load_val;
    logic         out_ready;
    logic         out_valid;
    logic [N-1:0] gray;
    logic [N-1:0] bin;
    logic         wrap;
    logic         overrun;
    logic         clr_ovr;

    int n_chk = 0;
    int n_fail = 0;

    gray_generador #(.N(N), .PRESCALE(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_down   (up_down),
        .load      (load),
        .load_val  (load_val),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .gray      (gray),
        .bin       (bin),
        .wrap      (wrap),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] g4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic next_word(output bit ok);
        int t;
        t = 0;
        do begin
            tick_clk();
            t++;
        end while (!out_valid && t < 20);
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en       = 1'($urandom);
            load     = 1'($urandom);
            load_val = 4'($urandom);
            tick_clk();
        end
        n_chk++;
        if (gray !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gray: got %b want 0000", gray);
        end
        n_chk++;
        if (bin !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_bin: got %b want 0000", bin);
        end
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_chk++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wrap: got %b want 0", wrap);
        end
        n_chk++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overrun: got %b want 0", overrun);
        end
        rst_n = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        tick_clk();
    endtask

    task automatic test_count_up();
        logic exp_v;
        logic [3:0] exp_b;
        en        = 1'b1;
        up_down   = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            tick_clk();
            exp_v = (c > 0) && (c % 4 == 0);
            n_chk++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL up_valid c=%0d: got %b want %b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                exp_b = 4'(c / 4);
                n_chk++;
                if (bin !== exp_b || gray !== g4(exp_b) || wrap !== 1'b0) begin
                    n_fail++;
                    $display("FAIL up_word c=%0d: got bin=%b gray=%b wrap=%b want bin=%b gray=%b wrap=0",
                             c, bin, gray, wrap, exp_b, g4(exp_b));
                end
            end
            if (c == 32) en = 1'b0;
        end
        tick_clk();
    endtask

    task automatic test_load_wrap();
        bit ok;
        load      = 1'b1;
        load_val  = 4'b1111;
        out_ready = 1'b0;
        tick_clk();
        load = 1'b0;
        n_chk++;
        if (gray !== 4'b1000 || bin !== 4'b1111 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL load_word: got gray=%b bin=%b valid=%b want 1000 1111 1",
                     gray, bin, out_valid);
        end
        en        = 1'b1;
        up_down   = 1'b1;
        out_ready = 1'b1;
        next_word(ok);
        n_chk++;
        if (!ok || gray !== 4'b0000 || bin !== 4'b0000 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_up: got ok=%b gray=%b bin=%b wrap=%b want 1 0000 0000 1",
                     ok, gray, bin, wrap);
        end
        next_word(ok);
        n_chk++;
        if (!ok || bin !== 4'b0001 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL after_wrap: got ok=%b bin=%b wrap=%b want 1 0001 0", ok, bin, wrap);
        end
    endtask

    task automatic test_count_down();
        bit ok;
        load     = 1'b1;
        load_val = 4'b0000;
        up_down  = 1'b0;
        tick_clk();
        load = 1'b0;
        next_word(ok);
        n_chk++;
        if (!ok || bin !== 4'b1111 || gray !== 4'b1000 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap: got ok=%b bin=%b gray=%b wrap=%b want 1 1111 1000 1",
                     ok, bin, gray, wrap);
        end
        next_word(ok);
        n_chk++;
        if (!ok || bin !== 4'b1110 || gray !== 4'b1001 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL down_step: got ok=%b bin=%b gray=%b wrap=%b want 1 1110 1001 0",
                     ok, bin, gray, wrap);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        load      = 1'b1;
        load_val  = 4'b0010;
        out_ready = 1'b0;
        up_down   = 1'b1;
        en        = 1'b1;
        tick_clk();
        load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick_clk();
            n_chk++;
            if (gray !== 4'b0011 || out_valid !== 1'b1 || overrun !== (i >= 4)) begin
                n_fail++;
                $display("FAIL hold i=%0d: got gray=%b valid=%b ovr=%b want 0011 1 %b",
                         i, gray, out_valid, overrun, (i >= 4));
            end
        end
        out_ready = 1'b1;
        next_word(ok);
        n_chk++;
        if (!ok || gray !== 4'b0010 || bin !== 4'b0011 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL after_hold: got ok=%b gray=%b bin=%b ovr=%b want 1 0010 0011 1",
                     ok, gray, bin, overrun);
        end
        clr_ovr = 1'b1;
        tick_clk();
        clr_ovr = 1'b0;
        n_chk++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovr: got %b want 0", overrun);
        end
    endtask

    task automatic test_load_accept();
        out_ready = 1'b0;
        load      = 1'b1;
        load_val  = 4'd5;
        tick_clk();
        load = 1'b0;
        repeat (3) tick_clk();
        load      = 1'b1;
        load_val  = 4'd9;
        out_ready = 1'b1;
        tick_clk();
        load = 1'b0;
        n_chk++;
        if (bin !== 4'd9 || gray !== 4'b1101 || out_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_tick: got bin=%b gray=%b valid=%b ovr=%b want 1001 1101 1 0",
                     bin, gray, out_valid, overrun);
        end
        out_ready = 1'b0;
        repeat (4) tick_clk();
        n_chk++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: got %b want 1", overrun);
        end
        load      = 1'b1;
        load_val  = 4'd6;
        out_ready = 1'b1;
        tick_clk();
        load = 1'b0;
        n_chk++;
        if (bin !== 4'd6 || gray !== 4'b0101 || out_valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL load_accept: got bin=%b gray=%b valid=%b ovr=%b want 0110 0101 1 1",
                     bin, gray, out_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        en        = 1'b1;
        up_down   = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick_clk();
        rst_n = 1'b0;
        tick_clk();
        n_chk++;
        if ({out_valid, bin, gray, wrap, overrun} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b bin=%b gray=%b wrap=%b ovr=%b want all 0",
                     out_valid, bin, gray, wrap, overrun);
        end
        rst_n = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            tick_clk();
            n_chk++;
            if (out_valid !== (c == 4)) begin
                n_fail++;
                $display("FAIL restart_valid c=%0d: got %b want %b", c, out_valid, (c == 4));
            end
        end
        n_chk++;
        if (bin !== 4'b0001 || gray !== 4'b0001 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_word: got bin=%b gray=%b wrap=%b want 0001 0001 0",
                     bin, gray, wrap);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 counting, 2 holding a word.
    int m_mode;
    int m_phase;
    int m_val;
    bit m_wrap;
    bit m_ovr;

    task automatic model_step();
        bit tk;
        bit dropped;
        dropped = 1'b0;
        if (!rst_n) begin
            m_mode  = 0;
            m_phase = 0;
            m_val   = 0;
            m_wrap  = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        tk = (m_mode != 0) && (m_phase == P - 1);
        if (load) begin
            m_val   = int'(load_val);
            m_wrap  = 1'b0;
            m_mode  = 2;
            m_phase = 0;
        end else if (m_mode == 0) begin
            m_phase = 0;
            if (en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!en) begin
                m_mode  = 0;
                m_phase = 0;
            end else if (tk) begin
                m_wrap  = up_down ? (m_val == 15) : (m_val == 0);
                m_val   = (m_val + (up_down ? 1 : 15)) % 16;
                m_mode  = 2;
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end else begin
            dropped = tk;
            m_phase = tk ? 0 : m_phase + 1;
            if (out_ready) begin
                m_wrap = 1'b0;
                m_mode = en ? 1 : 0;
                if (m_mode == 0) m_phase = 0;
            end
        end
        if (dropped) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
    endtask

    task automatic test_random();
        logic [10:0] exp;
        logic [3:0] eb;
        for (int i = 0; i < 400; i++) begin
            rst_n     = (i == 0) ? 1'b0 : ($urandom_range(99) != 0);
            en        = ($urandom_range(3) != 0);
            up_down   = 1'($urandom);
            out_ready = 1'($urandom);
            load      = ($urandom_range(15) == 0);
            load_val  = 4'($urandom);
            clr_ovr   = ($urandom_range(7) == 0);
            model_step();
            tick_clk();
            eb  = 4'(m_val);
            exp = {(m_mode == 2), eb, g4(eb), m_wrap, m_ovr};
            n_chk++;
            if ({out_valid, bin, gray, wrap, overrun} !== exp) begin
                n_fail++;
                $display("FAIL random i=%0d: got v=%b b=%b g=%b w=%b o=%b want v=%b b=%b g=%b w=%b o=%b",
                         i, out_valid, bin, gray, wrap, overrun,
                         exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        up_down   = 1'b1;
        load      = 1'b0;
        load_val  = '0;
        out_ready = 1'b0;
        clr_ovr   = 1'b0;
        test_reset();
        test_count_up();
        test_load_wrap();
        test_count_down();
        test_overrun();
        test_load_accept();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
